pll_hdmi_cfg_seq: RTL
=====================

# pll_hdmi_cfg_seq

Upstream of the HDMI PLL's Avalon-MM reconfiguration core. Buffers a list of PLL parameter writes (M/N/C counters, fractional K, bandwidth, charge pump) from the video-mode logic. On command, it replays them to the reconfig core as mode → parameters → start. It then waits for the PLL to re-lock and reports done or timeout.

## Interface
Parameters:
- DEPTH, 16 — buffered parameter-write entries (power of two, 2–64).
- LOCK_STABLE, 16 — consecutive cycles of pll_locked high required to declare lock.
- LOCK_TIMEOUT, 5000000 — cycles allowed from start-write acceptance to stable lock (100 ms at 50 MHz).

Ports:
- clk  in  1  management clock (50 MHz).
- rst_n  in  1  synchronous, active-low reset.
- cfg_wr  in  1  load one entry (cfg_addr, cfg_data) into buffer.
- cfg_addr  in  6  reconfig-core register address.
- cfg_data  in  32  register value.
- cfg_full  out  1  buffer holds DEPTH entries.
- cfg_go  in  1  single-cycle pulse: apply buffered entries.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at end of sequence (success or error).
- error  out  1  lock timeout; sticky until next accepted cfg_go.
- mgmt_address  out  6  Avalon-MM address to reconfig core.
- mgmt_write  out  1  Avalon-MM write.
- mgmt_writedata  out  32  Avalon-MM write data.
- mgmt_waitrequest  in  1  Avalon-MM waitrequest.
- pll_locked  in  1  PLL lock, already synchronised to clk.

## Operation
- Buffer: write pointer/count, entries stored in load order, replayed FIFO order.
- cfg_wr is accepted only in IDLE with count < DEPTH. It is ignored when full or busy.
- cfg_wr and cfg_go in the same IDLE cycle: the entry is stored first and included in the sequence.
- cfg_go is honoured only in IDLE; ignored while busy.
- cfg_go with count 0: no bus activity, done pulses next cycle, error cleared.
- States:
  - IDLE → MODE on cfg_go with count > 0.
  - MODE: write addr 0x00, data 0 (waitrequest mode) → PARAM.
  - PARAM: write entry[i]; after the last entry → START.
  - START: write addr 0x02, data 0 → WAIT_LOCK.
  - WAIT_LOCK: stable-lock counter and timeout counter both run.
    - Stable count reaching LOCK_STABLE → FINISH.
    - Timeout count reaching LOCK_TIMEOUT → FINISH with error=1.
    - pll_locked low resets the stable count.
  - FINISH: done=1, count cleared → IDLE.
- Avalon write rule: mgmt_address, mgmt_writedata and mgmt_write are held stable while mgmt_waitrequest=1. The write completes on the first rising edge with mgmt_write=1 and mgmt_waitrequest=0.
- Counters are sized by $clog2 of their parameter and saturate; no wrap-around.
- Reset mid-sequence:
  - State returns to IDLE on the next edge; mgmt_write drops and the buffer is cleared.
  - No done pulse.
  - Recovering the PLL is the system's responsibility.

## Timing
- Reset values: cfg_full=0, busy=0, done=0, error=0, mgmt_write=0, mgmt_address=0, mgmt_writedata=0.
- All outputs are registered.
- cfg_full reflects a cfg_wr on the following cycle.
- cfg_go at edge T: busy=1 and mgmt_write=1 (MODE) from T+1.
- With waitrequest always 0, writes are back-to-back: one per cycle, no gaps, N+2 write cycles.
- WAIT_LOCK is entered the cycle after START is accepted. The earliest FINISH is LOCK_STABLE cycles later.
- done and busy=0 appear together in the cycle after FINISH is reached.
- error updates in the same cycle as done.

## Structure
- Package pll_cfg_pkg holds:
  - register address constants: MODE=0x00, STATUS=0x01, START=0x02, N=0x03, M=0x04, C=0x05, K=0x07, BW=0x08, CP=0x09;
  - the state enum;
  - the entry struct {addr[5:0], data[31:0]}.
- One sub-module, pll_cfg_buf: DEPTH×38 register file with count/read index, write port and indexed read.

## Test plan
- Load M=0x00000808, N=0x00010000, K=0xE8F5C28F; waitrequest=0; pll_locked held 1 → bus sees (0x00,0), (0x04,…), (0x03,…), (0x07,…), (0x02,0) on 5 consecutive cycles. done arrives 16 cycles after WAIT_LOCK entry, error=0.
- waitrequest high for 3 cycles on the second write → address and data are held for 4 cycles, the write is issued exactly once, order is preserved.
- pll_locked toggles low at stable count 10, then stays high → lock declared 16 cycles after it returns high.
- pll_locked stuck 0, LOCK_TIMEOUT=100 → done with error=1 exactly 100 cycles after WAIT_LOCK entry. The next cfg_go clears error.
- Load 17 entries into DEPTH=16 → cfg_full=1, 17th dropped, 16 params replayed. cfg_wr/cfg_go while busy have no effect.
- rst_n low during PARAM with waitrequest=1 → mgmt_write=0 next cycle, busy=0, no done, buffer empty.

Source files
------------

// File: rtl/pll_hdmi_cfg_seq_pkg.sv
// Shared types for the HDMI PLL reconfig sequencer: register map, FSM states, buffer entry.
package pll_cfg_pkg;

    localparam logic [5:0] REG_MODE   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_START  = 6'h02;
    localparam logic [5:0] REG_N      = 6'h03;
    localparam logic [5:0] REG_M      = 6'h04;
    localparam logic [5:0] REG_C      = 6'h05;
    localparam logic [5:0] REG_K      = 6'h07;
    localparam logic [5:0] REG_BW     = 6'h08;
    localparam logic [5:0] REG_CP     = 6'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MODE,
        ST_PARAM,
        ST_START,
        ST_WAIT_LOCK,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } entry_t;

endpackage

// File: rtl/pll_hdmi_cfg_seq_if.sv
// Config-load, status and Avalon-MM reconfig signals of the sequencer; slave is the sequencer's view.
interface pll_hdmi_cfg_seq_if;
    logic        cfg_wr;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_full;
    logic        cfg_go;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    modport slave (
        input  cfg_wr, cfg_addr, cfg_data, cfg_go, mgmt_waitrequest, pll_locked,
        output cfg_full, busy, done, error, mgmt_address, mgmt_write, mgmt_writedata
    );

    modport master (
        output cfg_wr, cfg_addr, cfg_data, cfg_go, mgmt_waitrequest, pll_locked,
        input  cfg_full, busy, done, error, mgmt_address, mgmt_write, mgmt_writedata
    );
endinterface

// File: rtl/pll_hdmi_cfg_seq_buf.sv
// Parameter-write buffer: DEPTH entries stored in load order, read back by index (combinational read).
// A write lands on the next edge and is dropped when full; full_o is registered with the count.
module pll_cfg_buf
    import pll_cfg_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_i,
    input  entry_t                     wr_entry_i,
    input  logic                       clr_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output entry_t                     rd_entry_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    entry_t        mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          push;

    assign push = wr_i && !full_q && !clr_i;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (push)
            count_d = count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[count_q[AW-1:0]] <= wr_entry_i;
    end

    assign rd_entry_o = mem_q[rd_idx_i];
    assign count_o    = count_q;
    assign full_o     = full_q;
endmodule

// File: rtl/pll_hdmi_cfg_seq.sv
// HDMI PLL reconfig sequencer: replays buffered writes as mode, params, start, then waits for stable lock.
// Bus outputs registered, one write per cycle at zero waitrequest; address/data held while waitrequest is high.
module pll_hdmi_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 5000000
) (
    input  logic               clk,
    input  logic               rst_n,
    pll_hdmi_cfg_seq_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;   // next buffer entry to put on the bus
    logic [SW-1:0] stable_q, stable_d, stable_nx;
    logic [TW-1:0] tmo_q, tmo_d, tmo_nx;
    logic [5:0]    addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          accept, buf_wr, buf_clr, buf_full;
    logic [CW-1:0] buf_count;
    entry_t        rd_entry, wr_entry;

    assign wr_entry = {bus.cfg_addr, bus.cfg_data};
    assign buf_wr   = (state_q == ST_IDLE) && bus.cfg_wr;

    pll_cfg_buf #(.DEPTH(DEPTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_i       (buf_wr),
        .wr_entry_i (wr_entry),
        .clr_i      (buf_clr),
        .rd_idx_i   (rd_idx_q[AW-1:0]),
        .rd_entry_o (rd_entry),
        .count_o    (buf_count),
        .full_o     (buf_full)
    );

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        stable_d = stable_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        buf_clr  = 1'b0;
        accept   = write_q && !bus.mgmt_waitrequest;

        stable_nx = !bus.pll_locked ? '0 :
                    (stable_q == STABLE_MAX) ? stable_q : stable_q + SW'(1);
        tmo_nx    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TW'(1);

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_go) begin
                    error_d = 1'b0;
                    // a same-cycle cfg_wr is stored and counts towards the sequence
                    if (buf_count != '0 || (bus.cfg_wr && !buf_full)) begin
                        state_d  = ST_MODE;
                        busy_d   = 1'b1;
                        write_d  = 1'b1;
                        addr_d   = REG_MODE;
                        wdata_d  = '0;
                        rd_idx_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_MODE: begin
                if (accept) begin
                    state_d  = ST_PARAM;
                    addr_d   = rd_entry.addr;
                    wdata_d  = rd_entry.data;
                    rd_idx_d = CW'(1);
                end
            end
            ST_PARAM: begin
                if (accept) begin
                    if (rd_idx_q == buf_count) begin
                        state_d = ST_START;
                        addr_d  = REG_START;
                        wdata_d = '0;
                    end else begin
                        addr_d   = rd_entry.addr;
                        wdata_d  = rd_entry.data;
                        rd_idx_d = rd_idx_q + CW'(1);
                    end
                end
            end
            ST_START: begin
                if (accept) begin
                    state_d  = ST_WAIT_LOCK;
                    write_d  = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    stable_d = '0;
                    tmo_d    = '0;
                end
            end
            ST_WAIT_LOCK: begin
                stable_d = stable_nx;
                tmo_d    = tmo_nx;
                // lock wins when both limits are hit on the same cycle
                if (stable_nx == STABLE_MAX) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (tmo_nx == TMO_MAX) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end
            end
            ST_FINISH: begin
                buf_clr = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_idx_q <= '0;
            stable_q <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            stable_q <= stable_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.cfg_full       = buf_full;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.error          = error_q;
    assign bus.mgmt_address   = addr_q;
    assign bus.mgmt_write     = write_q;
    assign bus.mgmt_writedata = wdata_q;
endmodule
